adaptive_hll_driver: RTL and testbench



---
 rtl/adaptive_hll_driver.sv | 175 +++++++++++++++++
 tb/tb_adaptive_hll_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adaptive_hll_driver.sv
// Initiator-side driver for an adaptive HLL cell: buffers hashes, wakes the cell
// with one-hot touch pulses, then streams buffered hashes once the cell is active.
module adaptive_hll_driver #(
  parameter int unsigned HASH_WIDTH       = 64,
  parameter int unsigned IN_DEGREE        = 256,
  parameter int unsigned WAKEUP_THRESHOLD = 3,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned TIMEOUT          = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [HASH_WIDTH-1:0]         s_hash,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [IN_DEGREE-1:0]          connection_attempts,
  output logic [HASH_WIDTH-1:0]         hash_out,
  output logic                          hash_valid_out,
  input  logic                          cell_active,
  input  logic [7:0]                    cell_wakeup_count,
  output logic [1:0]                    state_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wake_timeout_err,
  output logic                          wake_count_err
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned TPW = $clog2(IN_DEGREE);
  localparam int unsigned KW  = $clog2(WAKEUP_THRESHOLD + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam logic [IN_DEGREE-1:0] TOUCH_ONE = IN_DEGREE'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAKE     = 2'd1,
    ST_WAIT_ACT = 2'd2,
    ST_STREAM   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [TPW-1:0]          touch_ptr_q, touch_ptr_d;
  logic [KW-1:0]           k_q, k_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [7:0]              expected_wc_q, expected_wc_d;
  logic [IN_DEGREE-1:0]    conn_q, conn_d;
  logic [HASH_WIDTH-1:0]   hash_out_q, hash_out_d;
  logic                    hash_valid_q, hash_valid_d;
  logic                    to_err_q, to_err_d;
  logic                    wc_err_q, wc_err_d;
  logic [HASH_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                    full, push, pop;

  assign full = (level_q == LW'(FIFO_DEPTH));
  assign push = s_valid && !full;

  // Next-state, FIFO bookkeeping and registered-output computation.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    touch_ptr_d   = touch_ptr_q;
    k_d           = k_q;
    timer_d       = timer_q;
    expected_wc_d = expected_wc_q;
    conn_d        = '0;
    hash_out_d    = hash_out_q;
    hash_valid_d  = 1'b0;
    to_err_d      = to_err_q;
    wc_err_d      = wc_err_q;
    pop           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          if (cell_active) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_WAKE;
            k_d     = '0;
          end
        end
      end
      ST_WAKE: begin
        conn_d      = TOUCH_ONE << touch_ptr_q;
        touch_ptr_d = TPW'(touch_ptr_q + TPW'(1));
        k_d         = KW'(k_q + KW'(1));
        if (k_q == KW'(WAKEUP_THRESHOLD - 1)) begin
          state_d = ST_WAIT_ACT;
          timer_d = '0;
        end
      end
      ST_WAIT_ACT: begin
        timer_d = TW'(timer_q + TW'(1));
        if (cell_active) begin
          state_d = ST_STREAM;
          if (cell_wakeup_count != 8'(expected_wc_q + 8'd1)) wc_err_d = 1'b1;
          expected_wc_d = cell_wakeup_count;
        end else if (timer_d == TW'(TIMEOUT)) begin
          // Retry continues from the current touch_ptr so new bits are touched.
          to_err_d = 1'b1;
          state_d  = ST_WAKE;
          k_d      = '0;
        end
      end
      ST_STREAM: begin
        if (!cell_active) begin
          state_d = ST_IDLE;
        end else if (level_q != '0) begin
          pop          = 1'b1;
          hash_out_d   = mem_q[rd_ptr_q];
          hash_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) wr_ptr_d = AW'(wr_ptr_q + AW'(1));
    if (pop)  rd_ptr_d = AW'(rd_ptr_q + AW'(1));
    case ({push, pop})
      2'b10:   level_d = LW'(level_q + LW'(1));
      2'b01:   level_d = LW'(level_q - LW'(1));
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      touch_ptr_q   <= '0;
      k_q           <= '0;
      timer_q       <= '0;
      expected_wc_q <= '0;
      conn_q        <= '0;
      hash_out_q    <= '0;
      hash_valid_q  <= 1'b0;
      to_err_q      <= 1'b0;
      wc_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      touch_ptr_q   <= touch_ptr_d;
      k_q           <= k_d;
      timer_q       <= timer_d;
      expected_wc_q <= expected_wc_d;
      conn_q        <= conn_d;
      hash_out_q    <= hash_out_d;
      hash_valid_q  <= hash_valid_d;
      to_err_q      <= to_err_d;
      wc_err_q      <= wc_err_d;
    end
  end

  // Hash storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= s_hash;
  end

  assign s_ready             = !full;
  assign connection_attempts = conn_q;
  assign hash_out            = hash_out_q;
  assign hash_valid_out      = hash_valid_q;
  assign state_o             = state_q;
  assign fifo_level          = level_q;
  assign wake_timeout_err    = to_err_q;
  assign wake_count_err      = wc_err_q;

endmodule

// File: tb/tb_adaptive_hll_driver.sv
// Self-checking bench for adaptive_hll_driver: vector table for the basic wake/stream
// flow, hand sequences for fill, timeout, count error, mid-wake reset and pointer wrap.
module tb_adaptive_hll_driver;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [63:0]  s_hash = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [255:0] connection_attempts;
  logic [63:0]  hash_out;
  logic         hash_valid_out;
  logic         cell_active = 1'b0;
  logic [7:0]   cell_wakeup_count = '0;
  logic [1:0]   state_o;
  logic [3:0]   fifo_level;
  logic         wake_timeout_err, wake_count_err;

  adaptive_hll_driver u_dut (
    .clk(clk), .reset(reset), .s_hash(s_hash), .s_valid(s_valid), .s_ready(s_ready),
    .connection_attempts(connection_attempts), .hash_out(hash_out),
    .hash_valid_out(hash_valid_out), .cell_active(cell_active),
    .cell_wakeup_count(cell_wakeup_count), .state_o(state_o), .fifo_level(fifo_level),
    .wake_timeout_err(wake_timeout_err), .wake_count_err(wake_count_err)
  );

  // Small instance for touch-pointer wrap with a short timeout.
  logic         r4_reset = 1'b1;
  logic [63:0]  r4_hash = '0;
  logic         r4_valid = 1'b0;
  logic         r4_ready;
  logic [3:0]   r4_conn;
  logic [63:0]  r4_hash_out;
  logic         r4_hv;
  logic         r4_active = 1'b0;
  logic [7:0]   r4_wc = '0;
  logic [1:0]   r4_state;
  logic [3:0]   r4_level;
  logic         r4_to_err, r4_wc_err;

  adaptive_hll_driver #(.IN_DEGREE(4), .TIMEOUT(4)) u_dut4 (
    .clk(clk), .reset(r4_reset), .s_hash(r4_hash), .s_valid(r4_valid), .s_ready(r4_ready),
    .connection_attempts(r4_conn), .hash_out(r4_hash_out), .hash_valid_out(r4_hv),
    .cell_active(r4_active), .cell_wakeup_count(r4_wc), .state_o(r4_state),
    .fifo_level(r4_level), .wake_timeout_err(r4_to_err), .wake_count_err(r4_wc_err)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every presented hash must be the oldest accepted, unconsumed word.
  logic [63:0] sb_exp;
  always @(negedge clk) begin
    if (hash_valid_out) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL stray_hash: got 0x%0h with no word pending", hash_out);
      end else begin
        sb_exp = exp_q.pop_front();
        chk("hash_order", 256'(hash_out), 256'(sb_exp));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [63:0] h, input logic act,
                       input logic [7:0] wc);
    s_valid = vld;
    s_hash  = h;
    cell_active = act;
    cell_wakeup_count = wc;
    if (vld && s_ready) exp_q.push_back(h);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 8'd0);
    tick();
    tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    tick();
    chk(name, 256'(exp_q.size()), 256'd0);
  endtask

  task automatic wait_state(input string name, input logic [1:0] st);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (state_o == st) found = 1'b1;
    end
    chk(name, 256'(found), 256'd1);
  endtask

  task automatic wait_conn(input string name, input logic [255:0] c);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (connection_attempts == c) found = 1'b1;
    end
    chk(name, 256'(found), 256'd1);
  endtask

  typedef struct {
    logic        vld;
    logic [63:0] h;
    logic        act;
    logic [7:0]  wc;
    logic [7:0]  conn;
    logic [1:0]  st;
    logic [3:0]  lvl;
    logic        hv;
  } vec_t;

  vec_t tbl [9];
  int   exp_lvl;
  int   got [6];
  int   n_got;
  int   exp_wrap [6];

  initial begin
    tbl[0] = '{1'b1, 64'hA5, 1'b0, 8'd0, 8'h00, 2'd0, 4'd1, 1'b0};
    tbl[1] = '{1'b0, 64'h00, 1'b0, 8'd0, 8'h00, 2'd1, 4'd1, 1'b0};
    tbl[2] = '{1'b0, 64'h00, 1'b0, 8'd0, 8'h01, 2'd1, 4'd1, 1'b0};
    tbl[3] = '{1'b0, 64'h00, 1'b0, 8'd0, 8'h02, 2'd1, 4'd1, 1'b0};
    tbl[4] = '{1'b0, 64'h00, 1'b0, 8'd0, 8'h04, 2'd2, 4'd1, 1'b0};
    tbl[5] = '{1'b0, 64'h00, 1'b0, 8'd0, 8'h00, 2'd2, 4'd1, 1'b0};
    tbl[6] = '{1'b0, 64'h00, 1'b1, 8'd1, 8'h00, 2'd3, 4'd1, 1'b0};
    tbl[7] = '{1'b0, 64'h00, 1'b1, 8'd1, 8'h00, 2'd3, 4'd0, 1'b1};
    tbl[8] = '{1'b0, 64'h00, 1'b1, 8'd1, 8'h00, 2'd3, 4'd0, 1'b0};
    exp_wrap = '{1, 2, 4, 8, 1, 2};

    // Reset state.
    do_reset();
    chk("rst_conn", connection_attempts, 256'd0);
    chk("rst_hash", 256'(hash_out), 256'd0);
    chk("rst_hv", 256'(hash_valid_out), 256'd0);
    chk("rst_state", 256'(state_o), 256'd0);
    chk("rst_level", 256'(fifo_level), 256'd0);
    chk("rst_ready", 256'(s_ready), 256'd1);
    chk("rst_to_err", 256'(wake_timeout_err), 256'd0);
    chk("rst_wc_err", 256'(wake_count_err), 256'd0);

    // Single hash wake-then-stream flow.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].vld, tbl[i].h, tbl[i].act, tbl[i].wc);
      tick();
      chk($sformatf("vec%0d_conn", i), connection_attempts, 256'(tbl[i].conn));
      chk($sformatf("vec%0d_state", i), 256'(state_o), 256'(tbl[i].st));
      chk($sformatf("vec%0d_level", i), 256'(fifo_level), 256'(tbl[i].lvl));
      chk($sformatf("vec%0d_hv", i), 256'(hash_valid_out), 256'(tbl[i].hv));
    end
    chk("vec_to_err", 256'(wake_timeout_err), 256'd0);
    chk("vec_wc_err", 256'(wake_count_err), 256'd0);

    // Back-to-back stream into an active cell.
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("b2b_ready%0d", i), 256'(s_ready), 256'd1);
      drive(1'b1, 64'(i), 1'b1, 8'd1);
      tick();
    end
    drive(1'b0, 64'd0, 1'b1, 8'd1);
    wait_drain("b2b_drain");

    // Fill while the cell sleeps: ready drops exactly at level 8.
    do_reset();
    exp_lvl = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("fill_level%0d", i), 256'(fifo_level), 256'(exp_lvl));
      chk($sformatf("fill_ready%0d", i), 256'(s_ready), 256'(exp_lvl < 8));
      drive(1'b1, 64'(100 + i), 1'b0, 8'd0);
      if (exp_lvl < 8) exp_lvl++;
      tick();
    end
    chk("fill_level_full", 256'(fifo_level), 256'd8);
    chk("fill_ready_full", 256'(s_ready), 256'd0);
    chk("fill_state", 256'(state_o), 256'd2);
    drive(1'b0, 64'd0, 1'b1, 8'd1);
    wait_drain("fill_drain");
    chk("fill_wc_err", 256'(wake_count_err), 256'd0);

    // Timeout after three pulses plus TIMEOUT cycles, retry on fresh bits.
    do_reset();
    drive(1'b1, 64'h77, 1'b0, 8'd0);
    tick();
    drive(1'b0, 64'd0, 1'b0, 8'd0);
    wait_conn("to_pulse3", 256'h4);
    repeat (254) tick();
    chk("to_err_early", 256'(wake_timeout_err), 256'd0);
    tick();
    chk("to_err_set", 256'(wake_timeout_err), 256'd1);
    tick();
    chk("to_retry0", connection_attempts, 256'h8);
    tick();
    chk("to_retry1", connection_attempts, 256'h10);
    tick();
    chk("to_retry2", connection_attempts, 256'h20);
    wait_state("to_wait", 2'd2);
    drive(1'b0, 64'd0, 1'b1, 8'd1);
    wait_drain("to_drain");
    chk("to_err_sticky", 256'(wake_timeout_err), 256'd1);
    chk("to_wc_err", 256'(wake_count_err), 256'd0);

    // Wrong wakeup count flags an error but streaming proceeds.
    do_reset();
    drive(1'b1, 64'h55, 1'b0, 8'd0);
    tick();
    drive(1'b0, 64'd0, 1'b0, 8'd0);
    wait_state("wc_wait", 2'd2);
    drive(1'b0, 64'd0, 1'b1, 8'd2);
    wait_drain("wc_drain");
    chk("wc_err_set", 256'(wake_count_err), 256'd1);
    chk("wc_to_err", 256'(wake_timeout_err), 256'd0);

    // Reset in the middle of a wake sequence.
    do_reset();
    drive(1'b1, 64'h99, 1'b0, 8'd0);
    tick();
    drive(1'b0, 64'd0, 1'b0, 8'd0);
    wait_conn("mid_pulse2", 256'h2);
    reset = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_conn", connection_attempts, 256'd0);
    chk("mid_state", 256'(state_o), 256'd0);
    chk("mid_level", 256'(fifo_level), 256'd0);
    chk("mid_ready", 256'(s_ready), 256'd1);
    reset = 1'b0;
    drive(1'b1, 64'h3C, 1'b0, 8'd0);
    tick();
    drive(1'b0, 64'd0, 1'b0, 8'd0);
    wait_state("mid_rewake", 2'd1);
    tick();
    chk("mid_first_bit", connection_attempts, 256'h1);
    wait_state("mid_wait", 2'd2);
    drive(1'b0, 64'd0, 1'b1, 8'd1);
    wait_drain("mid_drain");

    // Touch pointer wraps on a 4-wide bus across repeated timeouts.
    tick();
    r4_reset = 1'b0;
    r4_valid = 1'b1;
    r4_hash  = 64'h1;
    tick();
    r4_valid = 1'b0;
    n_got = 0;
    for (int i = 0; i < 200 && n_got < 6; i++) begin
      tick();
      if (r4_conn != 4'd0) begin
        got[n_got] = int'(r4_conn);
        n_got++;
      end
    end
    chk("wrap_count", 256'(n_got), 256'd6);
    for (int j = 0; j < 6; j++)
      chk($sformatf("wrap_pulse%0d", j), 256'(got[j]), 256'(exp_wrap[j]));
    chk("wrap_to_err", 256'(r4_to_err), 256'd1);
    chk("wrap_wc_err", 256'(r4_wc_err), 256'd0);
    chk("wrap_level", 256'(r4_level), 256'd1);
    chk("wrap_ready", 256'(r4_ready), 256'd1);
    chk("wrap_hv", 256'(r4_hv), 256'd0);
    chk("wrap_hash", 256'(r4_hash_out), 256'd0);
    chk("wrap_not_stream", 256'(r4_state == 2'd3), 256'd0);
    r4_wc = 8'd0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
